// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard-detection unit for the 5-stage pipeline.
// Keeps shadow EX/MEM/WB tags; drives EX/ID forwarding selects, a stall, and perf counters.
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WB_BYPASS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          id_branch,
    input  logic                          cnt_clr,
    output logic [2*NUM_SRC-1:0]          ex_fwd_sel,
    output logic [2*NUM_SRC-1:0]          id_fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_count,
    output logic [CNT_W-1:0]              fwd_count
);

    localparam int unsigned SRC_W = NUM_SRC * REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                  ex_valid, ex_regwrite, ex_memread;
    logic [REG_ADDR_W-1:0] ex_dst;
    logic [SRC_W-1:0]      ex_src;
    logic [NUM_SRC-1:0]    ex_src_used;
    logic                  mem_valid, mem_regwrite, mem_memread;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic                  wb_valid, wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_dst;

    logic ex_load;
    logic any_fwd;

    // A stage "writes r" only for real register writes; r0 never produces.
    function automatic logic writes(input logic v, input logic rw,
                                    input logic [REG_ADDR_W-1:0] d,
                                    input logic [REG_ADDR_W-1:0] r);
        return v && rw && (d == r) && (r != '0);
    endfunction

    always_comb begin
        ex_fwd_sel = '0;
        id_fwd_sel = '0;
        stall      = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_src_used[k]) begin
                if (writes(mem_valid, mem_regwrite, mem_dst, ex_src[k*REG_ADDR_W +: REG_ADDR_W])
                    && !mem_memread)
                    ex_fwd_sel[2*k +: 2] = 2'b10;
                else if (writes(wb_valid, wb_regwrite, wb_dst, ex_src[k*REG_ADDR_W +: REG_ADDR_W]))
                    ex_fwd_sel[2*k +: 2] = 2'b01;
            end
            if (id_branch && id_valid && id_src_used[k]) begin
                if (writes(mem_valid, mem_regwrite, mem_dst, id_src[k*REG_ADDR_W +: REG_ADDR_W])
                    && !mem_memread)
                    id_fwd_sel[2*k +: 2] = 2'b10;
                else if ((WB_BYPASS != 0)
                    && writes(wb_valid, wb_regwrite, wb_dst, id_src[k*REG_ADDR_W +: REG_ADDR_W]))
                    id_fwd_sel[2*k +: 2] = 2'b01;
            end
            if (id_valid && id_src_used[k]) begin
                // Load-use, or a branch waiting on an ALU result still in EX.
                if (writes(ex_valid, ex_regwrite, ex_dst, id_src[k*REG_ADDR_W +: REG_ADDR_W])
                    && (ex_memread || id_branch))
                    stall = 1'b1;
                if (id_branch && mem_memread
                    && writes(mem_valid, mem_regwrite, mem_dst, id_src[k*REG_ADDR_W +: REG_ADDR_W]))
                    stall = 1'b1;
            end
        end
    end

    assign ex_load = id_valid && !stall;
    assign any_fwd = |ex_fwd_sel;

    // Shadow tag pipeline; EX takes a bubble on stall or an empty ID slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_dst       <= '0;
            ex_src       <= '0;
            ex_src_used  <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_dst      <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_dst       <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_dst       <= mem_dst;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_dst      <= ex_dst;
            ex_valid     <= ex_load;
            ex_regwrite  <= ex_load ? id_regwrite : 1'b0;
            ex_memread   <= ex_load ? id_memread  : 1'b0;
            ex_dst       <= ex_load ? id_dst      : '0;
            ex_src       <= ex_load ? id_src      : '0;
            ex_src_used  <= ex_load ? id_src_used : '0;
        end
    end

    // Saturating counters; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else if (cnt_clr) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_W'(1);
            if (any_fwd && fwd_count != CNT_MAX)
                fwd_count <= fwd_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default instance plus a
// WB_BYPASS=0 / CNT_W=4 instance sharing the same ID stimulus.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_src = '0;
    logic [1:0]  id_src_used = '0;
    logic [4:0]  id_dst = '0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        id_branch = 1'b0;
    logic        cnt_clr = 1'b0;

    logic [3:0]  ex_fwd_sel, id_fwd_sel, nb_ex_fwd_sel, nb_id_fwd_sel;
    logic        stall, nb_stall;
    logic [15:0] stall_count, fwd_count;
    logic [3:0]  nb_stall_count, nb_fwd_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    hazard_forward_unit u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_branch(id_branch), .cnt_clr(cnt_clr),
        .ex_fwd_sel(ex_fwd_sel), .id_fwd_sel(id_fwd_sel), .stall(stall),
        .stall_count(stall_count), .fwd_count(fwd_count)
    );

    hazard_forward_unit #(.CNT_W(4), .WB_BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_branch(id_branch), .cnt_clr(cnt_clr),
        .ex_fwd_sel(nb_ex_fwd_sel), .id_fwd_sel(nb_id_fwd_sel), .stall(nb_stall),
        .stall_count(nb_stall_count), .fwd_count(nb_fwd_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one ID instruction (src0 in low bits), then let it settle.
    task automatic issue(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] d,
                         input logic rw, input logic mr, input logic br);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dst      = d;
        id_regwrite = rw;
        id_memread  = mr;
        id_branch   = br;
        #1;
    endtask

    task automatic flush(input int n, input logic clr);
        issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        cnt_clr = clr;
        for (int i = 0; i < n; i++) step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ex_fwd", 32'(ex_fwd_sel), 32'd0);
        check("rst_id_fwd", 32'(id_fwd_sel), 32'd0);
        check("rst_stall_cnt", 32'(stall_count), 32'd0);
        check("rst_fwd_cnt", 32'(fwd_count), 32'd0);
        step();
        reset = 1'b0;

        // ALU chain: add r3<-r1,r2 ; sub r4<-r3,r3
        issue(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
        check("alu_no_stall", 32'(stall), 32'd0);
        step();
        issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        check("alu_ex_fwd", 32'(ex_fwd_sel), 32'b1010);
        check("alu_stall", 32'(stall), 32'd0);
        step();
        check("alu_fwd_cnt", 32'(fwd_count), 32'd1);
        flush(3, 1'b0);

        // Double producer: add r5 ; or r5 ; and r6<-r5,r0
        issue(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        check("dbl_no_stall", 32'(stall), 32'd0);
        step();
        issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        check("dbl_ex_fwd", 32'(ex_fwd_sel), 32'b0010);
        flush(3, 1'b1);

        // Load-use: lw r2 ; add r7<-r2,r1
        issue(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        check("lu_stall1", 32'(stall), 32'd1);
        step();
        check("lu_stall2", 32'(stall), 32'd0);
        step();
        issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_ex_fwd", 32'(ex_fwd_sel), 32'b0001);
        check("lu_stall_cnt", 32'(stall_count), 32'd1);
        flush(3, 1'b0);

        // Load then branch: lw r4 ; beq r4,r1
        issue(1'b1, 5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd4, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1);
        check("lb_stall1", 32'(stall), 32'd1);
        step();
        check("lb_stall2", 32'(stall), 32'd1);
        check("lb_nb_stall2", 32'(nb_stall), 32'd1);
        step();
        check("lb_stall3", 32'(stall), 32'd0);
        check("lb_id_fwd", 32'(id_fwd_sel), 32'b0001);
        check("lb_nb_id_fwd", 32'(nb_id_fwd_sel), 32'b0000);
        flush(3, 1'b0);

        // ALU then branch: add r8<-r1,r2 ; beq r8,r8
        issue(1'b1, 5'd1, 5'd2, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        issue(1'b1, 5'd8, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1);
        check("ab_stall1", 32'(stall), 32'd1);
        step();
        check("ab_stall2", 32'(stall), 32'd0);
        check("ab_id_fwd", 32'(id_fwd_sel), 32'b1010);
        flush(3, 1'b0);

        // Reset mid-stall
        issue(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        check("mr_pre_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("mr_stall", 32'(stall), 32'd0);
        check("mr_stall_cnt", 32'(stall_count), 32'd0);
        check("mr_fwd_cnt", 32'(fwd_count), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("mr_post_stall", 32'(stall), 32'd0);
        step();
        check("mr_post_ex_fwd", 32'(ex_fwd_sel), 32'd0);
        check("mr_post_id_fwd", 32'(id_fwd_sel), 32'd0);
        flush(3, 1'b1);

        // Saturation: 20 load-use stalls
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
            step();
            issue(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
            step();
            step();
        end
        check("sat_nb_stall_cnt", 32'(nb_stall_count), 32'd15);
        check("sat_stall_cnt", 32'(stall_count), 32'd20);

        // Clear wins over a same-cycle increment
        issue(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        step();
        issue(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        check("clr_stall", 32'(stall), 32'd1);
        step();
        cnt_clr = 1'b0;
        check("clr_stall_cnt", 32'(stall_count), 32'd0);
        check("clr_nb_stall_cnt", 32'(nb_stall_count), 32'd0);
        check("clr_fwd_cnt", 32'(fwd_count), 32'd0);
        flush(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard-detection unit for the 5-stage pipeline, replacing the combinational forwarding block. It keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB destination and control tags, so the datapath only presents ID-stage decode. From that state it drives, per source operand:
- EX-stage forwarding selects;
- ID-stage branch-compare forwarding selects;
- a single stall for load-use and branch-dependency hazards.

It also keeps saturating performance counters.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- NUM_SRC, 2, source operands per instruction (channel k = bits [k*REG_ADDR_W +: REG_ADDR_W])
- CNT_W, 16, performance-counter width
- WB_BYPASS, 1, 1 = register file is not write-first, so MEM/WB is also forwarded into ID

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_ADDR_W  ID source register addresses
- id_src_used  in  NUM_SRC  source k is actually read
- id_dst  in  REG_ADDR_W  ID destination register
- id_regwrite  in  1  ID instruction writes a register
- id_memread  in  1  ID instruction is a load
- id_branch  in  1  ID instruction is a branch compared in ID
- cnt_clr  in  1  synchronous clear of both counters
- ex_fwd_sel  out  2*NUM_SRC  per-source EX mux select: 00 register file, 10 EX/MEM, 01 MEM/WB
- id_fwd_sel  out  2*NUM_SRC  per-source ID compare select, same encoding
- stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX
- stall_count  out  CNT_W  cycles with stall=1
- fwd_count  out  CNT_W  cycles with any ex_fwd_sel ≠ 00

## Operation
- **Shadow pipeline.** Three tag stages: EX, MEM, WB.
  - Each stage holds: valid, dst, regwrite, memread.
  - EX additionally holds src[NUM_SRC] and src_used.
- **Tag "writes r".** True when valid && regwrite && dst==r && r≠0. Register 0 is never a forwarding or hazard source.
- **Shadow advance every clock:** WB ← MEM, MEM ← EX, EX ← ID tags.
  - EX loads a bubble (all fields 0) when stall=1 or id_valid=0.
- **ex_fwd_sel[k]**, computed only if EX.src_used[k]:
  - 10 if MEM writes EX.src[k] and MEM.memread=0;
  - else 01 if WB writes EX.src[k];
  - else 00.
  - MEM has priority over WB.
- **id_fwd_sel[k]**, computed only if id_branch && id_valid && id_src_used[k]:
  - 10 if MEM writes id_src[k] and MEM.memread=0;
  - else 01 if WB_BYPASS=1 and WB writes id_src[k];
  - else 00.
- **stall = 1** when id_valid and, for some k with id_src_used[k], any of the following holds:
  - load-use: EX writes id_src[k] and EX.memread=1;
  - branch after ALU: id_branch and EX writes id_src[k];
  - branch after load: id_branch and MEM writes id_src[k] and MEM.memread=1.
- **Counters.**
  - stall_count +1 on each cycle with stall=1; fwd_count +1 on each cycle with ex_fwd_sel≠0.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr has priority over increment.

## Timing
- All outputs except the counters are combinational from shadow registers plus current ID inputs. Counters are registered.
- A load followed by a dependent ALU op produces one stall cycle; the consumer then reaches EX with ex_fwd_sel=01.
- A load followed by a dependent branch produces two stall cycles (EX-load hazard, then MEM-load hazard); the branch then sees id_fwd_sel=01, or 00 when WB_BYPASS=0.
- An ALU op followed by a dependent branch produces one stall cycle, then id_fwd_sel=10.
- Reset (async, any time, including mid-stall):
  - all shadow stages become bubbles and counters clear;
  - stall, ex_fwd_sel and id_fwd_sel read 0 while reset is high and in the first cycle after, until non-bubble tags advance.
- Both sources matching the same producer assert both channels identically; stall is the OR over channels.

## Test plan
- **ALU chain:** `add r3←r1,r2` then `sub r4←r3,r3` → next cycle ex_fwd_sel=1010, stall=0; fwd_count=1.
- **Double producer:** `add r5` then `or r5` then `and r6←r5,r0` → channel 0 selects 10 (MEM beats WB), channel 1 selects 00 (r0).
- **Load-use:** `lw r2` then `add r7←r2,r1` → stall=1 for exactly 1 cycle, then ex_fwd_sel[1:0]=01; stall_count=1.
- **Load then branch:** `lw r4` then `beq r4,r1` → stall=1 for 2 cycles, then id_fwd_sel[1:0]=01; repeat with WB_BYPASS=0 → 00.
- **Mid-sequence reset and clear:** reset asserted mid-stall → stall=0 and counters 0 immediately, and no forwarding in the following cycle. Force stall_count to saturate at CNT_W=4 → holds 15. cnt_clr → 0 on the next edge.
